// File: rtl/sync_filter.sv
// Multi-channel synchronizer + debounce filter for asynchronous level inputs.
// Optional rise/fall pulse outputs are built only when SYNC_FILTER_EDGE_EN is defined.

module sync_filter_lane #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   FILTER_CYCLES = 16,
   parameter logic RST_BIT       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_sig,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);
   localparam int CW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_q;
   logic                   w_s;
   logic                   w_match;
   logic                   w_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= {SYNC_STAGES{RST_BIT}};
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
   end

   assign w_s     = r_sync[SYNC_STAGES-1];
   assign w_match = (w_s == r_q);
   assign w_done  = !w_match && (r_cnt == LAST);

   // Any return to the accepted level forfeits the whole count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_q   <= RST_BIT;
      end else begin
         if (w_match || w_done) r_cnt <= '0;
         else                   r_cnt <= r_cnt + 1'b1;
         if (w_done) r_q <= w_s;
      end
   end

   assign o_q = r_q;

`ifdef SYNC_FILTER_EDGE_EN
   logic r_rise;
   logic r_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_done &  w_s;
         r_fall <= w_done & ~w_s;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif
endmodule

module sync_filter #(
   parameter int                  CHANNELS      = 4,
   parameter int                  SYNC_STAGES   = 2,
   parameter int                  FILTER_CYCLES = 16,
   parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] sig,
   output logic [CHANNELS-1:0] q,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      sync_filter_lane #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES),
         .RST_BIT      (RESET_VALUE[g])
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .i_sig (sig[g]),
         .o_q   (q[g]),
         .o_rise(rise[g]),
         .o_fall(fall[g])
      );
   end
endmodule

// File: doc/sync_filter.md
# sync_filter

Multi-channel input conditioner for asynchronous level signals such as buttons, switches, PHY status pins and link/interrupt lines. Each channel passes through a parametrised multi-flop synchronizer, then a per-channel stability filter (debouncer) that only accepts a new level after it has held for a programmable number of cycles. Optional one-cycle rise/fall pulses are produced for event-driven consumers. The block sits at the top-level pin boundary, between raw inputs and the control logic in the `clk` domain.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchronizer flops per channel (≥2).
- `FILTER_CYCLES`, 16: consecutive cycles a synchronized level must hold before it is accepted (≥1).
- `RESET_VALUE`, 0: `CHANNELS`-bit reset level for the synchronizer flops and `q`.

- `clk`, in, 1: sole clock. All logic is in this domain.
- `rst`, in, 1: reset, asynchronous, active-high.
- `sig`, in, `CHANNELS`: raw asynchronous inputs.
- `q`, out, `CHANNELS`: filtered, synchronized level (registered).
- `rise`, out, `CHANNELS`: one-cycle pulse when `q[i]` goes 0→1.
- `fall`, out, `CHANNELS`: one-cycle pulse when `q[i]` goes 1→0.

## Operation
- Per channel i, the synchronizer is a shift chain of `SYNC_STAGES` flops. Its last stage is `s[i]`.
- Per channel filter counter `cnt[i]` has width `$clog2(FILTER_CYCLES+1)`.
- Each `clk` edge, per channel:
  - If `s[i] == q[i]`: `cnt[i] <= 0`.
  - If `s[i] != q[i]` and `cnt[i] == FILTER_CYCLES-1`: `q[i] <= s[i]` and `cnt[i] <= 0`. Raise `rise[i]` if `s[i]` is 1, otherwise raise `fall[i]`.
  - Otherwise: `cnt[i] <= cnt[i] + 1`.
- A mismatch that disappears before the threshold clears the count. There is no partial credit.
- The counter never exceeds `FILTER_CYCLES-1` and never wraps.
- Channels are fully independent. Simultaneous updates on any subset of channels are allowed in the same cycle.
- `rise` and `fall` are registered. They are high for exactly one cycle, the same cycle `q` shows the new value. For a given channel they are never high together.
- `FILTER_CYCLES=1` degenerates to a plain synchronizer plus one register stage.

## Timing
- Reset values, applied asynchronously on `rst`:
  - synchronizer flops = `RESET_VALUE`
  - `q` = `RESET_VALUE`
  - `cnt` = 0
  - `rise` = 0, `fall` = 0
- Reset asserted mid-count discards the count. After release, filtering restarts from 0.
- If `sig` differs from `RESET_VALUE` at reset release, the block produces a normal `q` update and edge pulse after full latency. This is intended.
- Latency: a level applied before clock edge 0 and held stable appears on `q` (and `rise`/`fall`) after edge `SYNC_STAGES + FILTER_CYCLES`.
- Minimum accepted pulse width on `sig`: `FILTER_CYCLES` cycles. Shorter pulses are always rejected, up to the usual ±1 cycle metastability resolution uncertainty.
- Throughput: a channel can toggle `q` at most once per `FILTER_CYCLES` cycles.

## Configuration
- `SYNC_FILTER_EDGE_EN`
  - Defined: `rise`/`fall` registers and logic are built as described above.
  - Undefined: `rise` and `fall` are tied to constant 0, no edge flops are built, and `q` behaviour is identical.

## Test plan
Settings unless stated: `CHANNELS=4`, `SYNC_STAGES=2`, `FILTER_CYCLES=4`, `RESET_VALUE=0`, macro defined.
1. Hold `rst`=1 with `sig`=4'hF, then assert `rst` asynchronously mid-cycle → `q`=0, `rise`=`fall`=0 immediately. After release, `q`=4'hF exactly 6 edges later, with `rise`=4'hF for one cycle.
2. `sig[0]` steps 0→1 and holds → `q[0]`=1 at edge 6 after the change, `rise[0]` high for exactly that cycle, other channels unchanged.
3. `sig[0]` glitches high for 3 cycles then returns low → `q[0]` stays 0, no pulse.
4. Bounce on `sig[1]`: high 3, low 1, high 10 → `q[1]` rises 6 edges after the final rising transition, with a single `rise[1]` pulse.
5. Same cycle: `sig[2]` 1→0 and `sig[3]` 0→1, both settled → both `q` bits update on the same edge, with `fall[2]`=1 and `rise[3]`=1 together.
6. Assert `rst` 2 cycles into a count, then rebuild with the macro undefined → `q` returns to 0 at once and the count restarts from 0 after release. Without the macro, `rise`=`fall`=0 throughout while `q` matches the macro-defined run.
